if_litebpu: RTL

Static branch predictor and target generator in the instruction-fetch stage. Each cycle it consumes the mini-decoder's branch/jump classification and immediate for the instruction at `pc`, and produces the taken prediction and next-fetch target. For `jalr` it obtains the rs1 base value:

- from a dedicated x1 tap, or
- through a one-cycle regfile read handshake, stalling fetch with `bpu_wait` while the base is unavailable.

---
 rtl/if_litebpu_pkg.sv | 26 ++
 rtl/if_bpu_adder.sv | 19 +
 rtl/if_litebpu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/if_litebpu_pkg.sv
// ----------------------------------------------------------------------------
// if_litebpu_pkg
//   Shared constants and types for the fetch-stage static branch predictor.
//   PC_Size / XLEN  : PC/target width and register width
//   bpu_state_e     : xN-base read FSM encoding (IDLE=0, RS1RD=1)
//   X0 / X1         : register index constants used for jalr base selection
//   idx_is_xn()     : true for any rs1 index that needs a regfile read
// ----------------------------------------------------------------------------
package if_litebpu_pkg;

  localparam int PC_Size = 32;
  localparam int XLEN    = 32;

  typedef enum logic {
    BPU_IDLE  = 1'b0,
    BPU_RS1RD = 1'b1
  } bpu_state_e;

  localparam logic [4:0] X0 = 5'd0;
  localparam logic [4:0] X1 = 5'd1;

  function automatic logic idx_is_xn(input logic [4:0] idx);
    return (idx != X0) && (idx != X1);
  endfunction

endpackage

// File: rtl/if_bpu_adder.sv
// ----------------------------------------------------------------------------
// if_bpu_adder
//   Single target adder shared by every prediction case (jal, bxx, jalr).
//   The sum wraps modulo 2^PC_Size; carry-out is dropped.
//   i_op1 : base (pc, 0, x1 or rs1 read data)
//   i_op2 : branch/jump immediate, already sized to PC_Size
//   o_sum : predicted target
// ----------------------------------------------------------------------------
module if_bpu_adder
  import if_litebpu_pkg::*;
(
  input  logic [PC_Size-1:0] i_op1,
  input  logic [PC_Size-1:0] i_op2,
  output logic [PC_Size-1:0] o_sum
);

  assign o_sum = i_op1 + i_op2;

endmodule

// File: rtl/if_litebpu.sv
// ----------------------------------------------------------------------------
// if_litebpu
//   Static branch predictor / next-fetch target generator in the IF stage.
//   jal and backward bxx predict taken, forward bxx not taken, jalr always
//   taken. The jalr base comes from x0 (zero), the dedicated x1 tap, or a
//   one-cycle regfile read of rs1 that stalls fetch until the data returns.
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     dec_i_valid         : decoded instruction valid this cycle
//     dec_i_ready         : fetch accepts the current prediction
//     flush               : pipeline flush from EXU
//     pc                  : PC of the decoded instruction
//     dec_ifj/jal/jalr/bxx: mini-decoder classification
//     dec_bjp_imm         : sign-extended branch/jump immediate
//     dec_jalr_rs1_indx   : jalr rs1 index
//     oitf_empty          : no long-pipe instruction outstanding
//     ir_empty/ir_rs1en   : IR stage occupancy / IR uses regfile rs1 port
//     ir_rd_wen/ir_rd_idx : IR instruction destination
//     rf2bpu_x1           : live x1 value
//     rf2bpu_rs1          : regfile rs1 read data (valid cycle after enable)
//     bpu2rf_rs1_ena      : rs1 read request
//     bpu_wait            : stall fetch, prediction not yet valid
//     prdt_taken/prdt_pc  : prediction and target
//
//   FSM states
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     BPU_IDLE  | no rs1 read in flight; jalr xN waits here for a free port
//     BPU_RS1RD | rs1 read issued; rf2bpu_rs1 holds the jalr base until the
//               | prediction is accepted or flushed
// ----------------------------------------------------------------------------
module if_litebpu
  import if_litebpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_i_valid,
  input  logic               dec_i_ready,
  input  logic               flush,
  input  logic [PC_Size-1:0] pc,
  input  logic               dec_ifj,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  input  logic [4:0]         dec_jalr_rs1_indx,
  input  logic               oitf_empty,
  input  logic               ir_empty,
  input  logic               ir_rs1en,
  input  logic               ir_rd_wen,
  input  logic [4:0]         ir_rd_idx,
  input  logic [XLEN-1:0]    rf2bpu_x1,
  input  logic [XLEN-1:0]    rf2bpu_rs1,
  output logic               bpu2rf_rs1_ena,
  output logic               bpu_wait,
  output logic               prdt_taken,
  output logic [PC_Size-1:0] prdt_pc
);

  bpu_state_e r_state;

  logic               w_v;
  logic               w_rs1_x0;
  logic               w_rs1_x1;
  logic               w_rs1_xn;
  logic               w_ir_wr_x1;
  logic               w_ir_wr_rs1;
  logic               w_dep_x1;
  logic               w_dep_xn;
  logic               w_free;
  logic               w_xn_jalr;
  logic               w_rs1_ena;
  logic               w_accept;
  logic [PC_Size-1:0] w_base;
  logic [PC_Size-1:0] w_imm;
  logic [PC_Size-1:0] w_target;

  // flush gates the qualifier, which suppresses taken, wait and the enable
  assign w_v = dec_i_valid & dec_ifj & ~flush;

  assign w_rs1_x0 = (dec_jalr_rs1_indx == X0);
  assign w_rs1_x1 = (dec_jalr_rs1_indx == X1);
  assign w_rs1_xn = idx_is_xn(dec_jalr_rs1_indx);

  assign w_ir_wr_x1  = ~ir_empty & ir_rd_wen & (ir_rd_idx == X1);
  assign w_ir_wr_rs1 = ~ir_empty & ir_rd_wen & (ir_rd_idx == dec_jalr_rs1_indx);

  assign w_dep_x1  = dec_jalr & w_rs1_x1 & (~oitf_empty | w_ir_wr_x1);
  assign w_dep_xn  = ~oitf_empty | w_ir_wr_rs1;
  assign w_free    = ir_empty | ~ir_rs1en;
  assign w_xn_jalr = dec_jalr & w_rs1_xn;

  // read port is borrowed only when IR is not using it and no older
  // instruction can still write the register being read
  assign w_rs1_ena = (r_state == BPU_IDLE) & w_v & w_xn_jalr & w_free & ~w_dep_xn;

  assign w_accept = dec_i_valid & dec_i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BPU_IDLE;
    end else if (flush) begin
      r_state <= BPU_IDLE;
    end else if (r_state == BPU_IDLE) begin
      if (w_rs1_ena) r_state <= BPU_RS1RD;
    end else begin
      // valid dropping without acceptance keeps the read data parked
      if (w_accept) r_state <= BPU_IDLE;
    end
  end

  // base mux feeding the single shared adder
  always_comb begin
    w_base = pc;
    if (dec_jalr) begin
      if (w_rs1_x0)      w_base = '0;
      else if (w_rs1_x1) w_base = PC_Size'(rf2bpu_x1);
      else               w_base = PC_Size'(rf2bpu_rs1);
    end
  end

  assign w_imm = PC_Size'(dec_bjp_imm);

  if_bpu_adder u_adder (
    .i_op1 (w_base),
    .i_op2 (w_imm),
    .o_sum (w_target)
  );

  assign bpu2rf_rs1_ena = w_rs1_ena;
  assign bpu_wait       = w_v & (w_dep_x1 | (w_xn_jalr & (r_state == BPU_IDLE)));
  // bxx static rule: backward (negative immediate) taken, forward not taken
  assign prdt_taken     = w_v & (dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[XLEN-1]));
  assign prdt_pc        = w_target;

endmodule
